// File: rtl/microsequencer_ctrl.sv
// Control-store address sequencer: holds the current microinstruction address
// and picks the next one from the encoder, zero, pipeline field, incrementer
// or a small LIFO of return addresses. Misuse of the stack or the select is
// reported on sticky flags that only reset clears.
module microsequencer_ctrl #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic           Clk,
    input  logic           Clr,
    input  logic [2:0]     M,
    input  logic [AW-1:0]  enc_addr,
    input  logic [AW-1:0]  pipe_addr,
    input  logic           push,
    input  logic           hold,
    output logic [AW-1:0]  state,
    output logic [SPW-1:0] sp,
    output logic           ovf,
    output logic           unf,
    output logic           bad_sel
);

    // Stack entry index width; sp itself needs one more code for "full".
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] SEL_ENC  = 3'b000;
    localparam logic [2:0] SEL_ZERO = 3'b001;
    localparam logic [2:0] SEL_PIPE = 3'b010;
    localparam logic [2:0] SEL_INC  = 3'b011;
    localparam logic [2:0] SEL_POP  = 3'b100;

    localparam logic [AW-1:0]  ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]  ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_ZERO   = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE    = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_FULL   = SPW'(DEPTH);
    localparam logic [IW-1:0]  IDX_ZERO  = {IW{1'b0}};

    logic [AW-1:0]  state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           bad_sel_q, bad_sel_d;
    logic [AW-1:0]  stack_q [DEPTH];

    logic [AW-1:0]  inc_s;
    logic [IW-1:0]  top_idx_s;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           wr_en_s;
    logic [IW-1:0]  wr_idx_s;

    // Shared helpers: incremented address, stack top index and occupancy.
    always_comb begin
        inc_s     = state_q + ADDR_ONE;
        top_idx_s = IW'(sp_q - SP_ONE);
        empty_s   = (sp_q == SP_ZERO);
        full_s    = (sp_q == SP_FULL);
        pop_s     = (M == SEL_POP);
    end

    // Next-state selection, stack pointer bookkeeping and sticky flag updates.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        bad_sel_d = bad_sel_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = top_idx_s;
        if (!hold) begin
            case (M)
                SEL_ENC:  state_d = enc_addr;
                SEL_ZERO: state_d = ADDR_ZERO;
                SEL_PIPE: state_d = pipe_addr;
                SEL_INC:  state_d = inc_s;
                SEL_POP: begin
                    if (!empty_s) begin
                        state_d = stack_q[top_idx_s];
                    end else begin
                        state_d = ADDR_ZERO;
                        unf_d   = 1'b1;
                    end
                end
                default: begin
                    state_d   = ADDR_ZERO;
                    bad_sel_d = 1'b1;
                end
            endcase

            if (pop_s) begin
                if (push) begin
                    // Pop and push together: the top slot is recycled in place.
                    wr_en_s = 1'b1;
                    if (empty_s) begin
                        wr_idx_s = IDX_ZERO;
                        sp_d     = SP_ONE;
                    end else begin
                        wr_idx_s = top_idx_s;
                        sp_d     = sp_q;
                    end
                end else if (!empty_s) begin
                    sp_d = sp_q - SP_ONE;
                end else begin
                    sp_d = sp_q;
                end
            end else if (push) begin
                if (!full_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = IW'(sp_q);
                    sp_d     = sp_q + SP_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                sp_d = sp_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer state, stack pointer and sticky flags.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= ADDR_ZERO;
            sp_q      <= SP_ZERO;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            bad_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            bad_sel_q <= bad_sel_d;
        end
    end

    // Return-address storage; a push always saves the address after the current one.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= ADDR_ZERO;
            end
        end else if (wr_en_s) begin
            stack_q[wr_idx_s] <= inc_s;
        end else begin
            stack_q[wr_idx_s] <= stack_q[wr_idx_s];
        end
    end

    assign state   = state_q;
    assign sp      = sp_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign bad_sel = bad_sel_q;

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// Scoreboard bench for microsequencer_ctrl: stimulus pushes the reference
// model's expected post-edge outputs into a queue, a monitor pops and compares.
module tb_microsequencer_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           Clk;
    logic           Clr;
    logic [2:0]     M;
    logic [AW-1:0]  enc_addr;
    logic [AW-1:0]  pipe_addr;
    logic           push;
    logic           hold;
    logic [AW-1:0]  state;
    logic [SPW-1:0] sp;
    logic           ovf;
    logic           unf;
    logic           bad_sel;

    microsequencer_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Clr(Clr), .M(M), .enc_addr(enc_addr), .pipe_addr(pipe_addr),
        .push(push), .hold(hold), .state(state), .sp(sp), .ovf(ovf),
        .unf(unf), .bad_sel(bad_sel)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [7:0] st;
        int         sp;
        bit         ovf;
        bit         unf;
        bit         bad;
        string      tag;
    } exp_t;

    exp_t expq[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain address value plus a queue used as the LIFO.
    logic [7:0] m_state;
    logic [7:0] m_stk[$];
    bit m_ovf, m_unf, m_bad;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 8'h00;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_bad = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] m, input logic [7:0] enc, input logic [7:0] pipe,
                              input logic pu, input logic ho);
        logic [7:0] inc;
        logic [7:0] nxt;
        if (ho) return;
        inc = m_state + 8'd1;
        nxt = 8'h00;
        case (m)
            3'd0: nxt = enc;
            3'd1: nxt = 8'h00;
            3'd2: nxt = pipe;
            3'd3: nxt = inc;
            3'd4: begin
                if (m_stk.size() > 0) nxt = m_stk.pop_back();
                else begin nxt = 8'h00; m_unf = 1'b1; end
            end
            default: begin nxt = 8'h00; m_bad = 1'b1; end
        endcase
        if (pu) begin
            if (m == 3'd4 || m_stk.size() < DEPTH) m_stk.push_back(inc);
            else m_ovf = 1'b1;
        end
        m_state = nxt;
    endtask

    task automatic step(input logic [2:0] m, input logic [7:0] enc, input logic [7:0] pipe,
                        input logic pu, input logic ho, input string tag);
        exp_t e;
        @(negedge Clk);
        #1;
        M = m; enc_addr = enc; pipe_addr = pipe; push = pu; hold = ho;
        model_step(m, enc, pipe, pu, ho);
        e.st = m_state; e.sp = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf; e.bad = m_bad;
        e.tag = tag;
        expq.push_back(e);
    endtask

    // Asynchronous clear mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge Clk);
        #1;
        hold = 1'b1;
        Clr  = 1'b0;
        #1;
        model_reset();
        cmp({tag, ".state"}, 32'(state), 32'(m_state));
        cmp({tag, ".sp"}, 32'(sp), 32'(m_stk.size()));
        cmp({tag, ".flags"}, {29'd0, ovf, unf, bad_sel}, 32'd0);
        #1;
        Clr = 1'b1;
    endtask

    // Monitor: one registered output set per clock, checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp({e.tag, ".state"}, 32'(state), 32'(e.st));
                cmp({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
                cmp({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
                cmp({e.tag, ".unf"}, 32'(unf), 32'(e.unf));
                cmp({e.tag, ".bad_sel"}, 32'(bad_sel), 32'(e.bad));
            end
        end
    end

    initial begin
        int r;
        logic [2:0] rm;
        Clr = 1'b0; M = 3'd0; enc_addr = 8'h00; pipe_addr = 8'h00; push = 1'b0; hold = 1'b1;
        model_reset();
        #12;
        cmp("por.state", 32'(state), 32'h0);
        cmp("por.sp", 32'(sp), 32'h0);
        cmp("por.flags", {29'd0, ovf, unf, bad_sel}, 32'd0);
        #1 Clr = 1'b1;

        // Mid-run clear with state 0x37 and two stacked entries.
        step(3'd2, 8'h00, 8'h36, 1'b1, 1'b0, "pre_rst_a");
        step(3'd3, 8'h00, 8'h00, 1'b1, 1'b0, "pre_rst_b");
        do_reset("mid_rst");

        // Every source.
        step(3'd0, 8'h40, 8'h00, 1'b0, 1'b0, "src_enc");
        for (int i = 0; i < 3; i++) step(3'd3, 8'h00, 8'h00, 1'b0, 1'b0, "src_inc");
        step(3'd2, 8'h00, 8'h9A, 1'b0, 1'b0, "src_pipe");
        step(3'd1, 8'h00, 8'h00, 1'b0, 1'b0, "src_zero");

        // Incrementer wrap, both as next state and as pushed return address.
        step(3'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "wrap_set");
        step(3'd3, 8'h00, 8'h00, 1'b0, 1'b0, "wrap_inc");
        step(3'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "wrap_set2");
        step(3'd3, 8'h00, 8'h00, 1'b1, 1'b0, "wrap_push");
        step(3'd4, 8'h00, 8'h00, 1'b0, 1'b0, "wrap_pop");

        // Nested call/return.
        step(3'd2, 8'h00, 8'h10, 1'b0, 1'b0, "call_set");
        step(3'd2, 8'h00, 8'h80, 1'b1, 1'b0, "call1");
        step(3'd2, 8'h00, 8'hA0, 1'b1, 1'b0, "call2");
        step(3'd4, 8'h00, 8'h00, 1'b0, 1'b0, "ret2");
        step(3'd4, 8'h00, 8'h00, 1'b0, 1'b0, "ret1");

        // Overflow, push+pop while full, then drain to underflow.
        step(3'd2, 8'h00, 8'h20, 1'b0, 1'b0, "lim_set");
        for (int i = 0; i < 5; i++) step(3'd3, 8'h00, 8'h00, 1'b1, 1'b0, "lim_push");
        step(3'd4, 8'h00, 8'h00, 1'b1, 1'b0, "lim_pushpop_full");
        for (int i = 0; i < 5; i++) step(3'd4, 8'h00, 8'h00, 1'b0, 1'b0, "lim_pop");
        step(3'd4, 8'h00, 8'h00, 1'b1, 1'b0, "lim_pushpop_empty");

        // Hold freezes everything; illegal select.
        for (int i = 0; i < 3; i++) step(3'd3, 8'h00, 8'h00, 1'b1, 1'b1, "hold");
        step(3'd5, 8'h00, 8'h00, 1'b0, 1'b0, "bad_sel");
        step(3'd3, 8'h00, 8'h00, 1'b0, 1'b0, "bad_sticky");
        do_reset("rst_flags");

        // Randomized traffic with a clear in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset("rnd_rst");
            r = $urandom_range(0, 99);
            if (r < 10) rm = 3'd0;
            else if (r < 18) rm = 3'd1;
            else if (r < 30) rm = 3'd2;
            else if (r < 60) rm = 3'd3;
            else if (r < 92) rm = 3'd4;
            else if (r < 94) rm = 3'($urandom_range(5, 7));
            else rm = 3'd3;
            step(rm, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 5) == 0), "rnd");
        end

        repeat (3) @(negedge Clk);
        #2;
        cmp("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
